// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl -- fetch-stage PC sequencer and branch-recovery unit.
//
// Selects the next fetch PC for the dual-issue fetch pair {PCF, PCF+4} from
// the local branch predictor output, carries the prediction into Decode with
// the pair, checks it against the branch outcomes resolved in Decode and, on
// a mismatch, redirects fetch, squashes the wrong-path pair and counts it.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   stallF / stallD          hold fetch PC / hold Decode registers
//   pred_taken[1:0]          predictor taken (bit0 = slot1, bit1 = slot2)
//   PC_pred                  predicted target
//   pcsrcD1/2, PCBranchD1/2  resolved outcome and target of Decode slots
//   PCF, slot2_validF        fetch PC and slot2-on-path flag
//   PCD, validD, slot2_validD, predD   Decode pair state
//   redirect, redirect_pc    misprediction recovery (redirect_pc = 0 when idle)
//   br_cnt, mp_cnt           saturating resolved-branch / mispredict counters
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallF,
  input  logic             stallD,
  input  logic [1:0]       pred_taken,
  input  logic [31:0]      PC_pred,
  input  logic             pcsrcD1,
  input  logic             pcsrcD2,
  input  logic [31:0]      PCBranchD1,
  input  logic [31:0]      PCBranchD2,
  output logic [31:0]      PCF,
  output logic             slot2_validF,
  output logic [31:0]      PCD,
  output logic             validD,
  output logic             slot2_validD,
  output logic [1:0]       predD,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  logic [31:0]      r_pcf;
  logic [31:0]      r_pcd;
  logic [31:0]      r_predtgtd;
  logic [1:0]       r_predd;
  logic             r_validd;
  logic             r_slot2_validd;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mp_cnt;

  logic             w_res_active;
  logic             w_redirect;
  logic [31:0]      w_redirect_pc;
  logic             w_br_inc;
  logic [31:0]      w_next_pc;

  assign w_res_active = r_validd & ~stallD;

  // Slot2 is only examined when slot1 is resolved not-taken and was
  // predicted not-taken, so at most one slot contributes a taken branch.
  always_comb begin
    w_redirect    = 1'b0;
    w_redirect_pc = '0;
    w_br_inc      = 1'b0;
    if (w_res_active) begin
      if (pcsrcD1) begin
        w_br_inc = 1'b1;
        if (!r_predd[0] || (r_predtgtd != PCBranchD1)) begin
          w_redirect    = 1'b1;
          w_redirect_pc = PCBranchD1;
        end
      end else if (r_predd[0]) begin
        // Predicted taken but fell through: slot2 was squashed, refetch it.
        w_redirect    = 1'b1;
        w_redirect_pc = r_pcd + 32'd4;
      end else if (r_slot2_validd) begin
        if (pcsrcD2) begin
          w_br_inc = 1'b1;
          if (!r_predd[1] || (r_predtgtd != PCBranchD2)) begin
            w_redirect    = 1'b1;
            w_redirect_pc = PCBranchD2;
          end
        end else if (r_predd[1]) begin
          w_redirect    = 1'b1;
          w_redirect_pc = r_pcd + 32'd8;
        end
      end
    end
  end

  always_comb begin
    w_next_pc = r_pcf + 32'd8;
    if (w_redirect)
      w_next_pc = w_redirect_pc;
    else if (stallF)
      w_next_pc = r_pcf;
    else if (|pred_taken)
      w_next_pc = PC_pred;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_pcf <= RESET_PC;
    else
      r_pcf <= w_next_pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcd          <= '0;
      r_predtgtd     <= '0;
      r_predd        <= '0;
      r_validd       <= 1'b0;
      r_slot2_validd <= 1'b0;
    end else if (!stallD) begin
      if (w_redirect || stallF) begin
        r_predd        <= '0;
        r_validd       <= 1'b0;
        r_slot2_validd <= 1'b0;
      end else begin
        r_pcd          <= r_pcf;
        r_predtgtd     <= PC_pred;
        r_predd        <= pred_taken;
        r_validd       <= 1'b1;
        r_slot2_validd <= ~pred_taken[0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_cnt <= '0;
      r_mp_cnt <= '0;
    end else begin
      if (w_br_inc && (r_br_cnt != '1))
        r_br_cnt <= r_br_cnt + 1'b1;
      if (w_redirect && (r_mp_cnt != '1))
        r_mp_cnt <= r_mp_cnt + 1'b1;
    end
  end

  assign PCF          = r_pcf;
  assign slot2_validF = ~pred_taken[0];
  assign PCD          = r_pcd;
  assign validD       = r_validd;
  assign slot2_validD = r_slot2_validd;
  assign predD        = r_predd;
  assign redirect     = w_redirect;
  assign redirect_pc  = w_redirect_pc;
  assign br_cnt       = r_br_cnt;
  assign mp_cnt       = r_mp_cnt;

endmodule
